master_tile_sequencer: RTL and testbench

- Parametrised successor to the single-pass multiply controller.
- Walks a full tiled matrix multiply, one SYS_ARR_DIM x SYS_ARR_DIM tile at a time, over row tiles, column tiles and intermediate-dimension (k) tiles.
- For each tile it runs three phases in order: weight mem->fifo (wmf), weight fifo->array (wfa), data mem->calc (dmc). It also generates tile addresses and accumulator-table coordinates.
- Optional overlap mode prefetches the next weight tile into the fifo while the current data tile is being computed.

---
 rtl/master_tile_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_master_tile_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_tile_sequencer.sv
// rtl/master_tile_sequencer.sv - tiled matmul sequencer: wmf/wfa/dmc phases per tile with optional weight prefetch
module master_tile_sequencer #(
  parameter int SYS_ARR_DIM  = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int MAX_INTERMED = 128,
  parameter int ADDR_WIDTH   = 16,
  localparam int RT_W = $clog2(MAX_OUT_ROWS / SYS_ARR_DIM) + 1,
  localparam int CT_W = $clog2(MAX_OUT_COLS / SYS_ARR_DIM) + 1,
  localparam int KT_W = $clog2(MAX_INTERMED / SYS_ARR_DIM) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  overlap_mode,
  input  logic [RT_W-1:0]       row_tiles,
  input  logic [CT_W-1:0]       col_tiles,
  input  logic [KT_W-1:0]       k_tiles,
  input  logic [ADDR_WIDTH-1:0] base_weight,
  input  logic [ADDR_WIDTH-1:0] base_data,
  output logic                  busy,
  output logic                  done,
  output logic                  wmf_en,
  input  logic                  wmf_done,
  output logic [ADDR_WIDTH-1:0] wmf_addr,
  output logic                  wfa_en,
  input  logic                  wfa_done,
  output logic                  dmc_en,
  input  logic                  dmc_done,
  output logic [ADDR_WIDTH-1:0] dmc_addr,
  output logic [RT_W-2:0]       accum_row,
  output logic [CT_W-2:0]       accum_col,
  output logic                  accum_clear
);

  typedef enum logic [2:0] {IDLE, W_MEM_FIFO, W_FIFO_ARR, D_MEM_CALC, FINISH} state_t;

  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_OUT_ROWS / SYS_ARR_DIM);
  localparam logic [CT_W-1:0] CT_MAX = CT_W'(MAX_OUT_COLS / SYS_ARR_DIM);
  localparam logic [KT_W-1:0] KT_MAX = KT_W'(MAX_INTERMED / SYS_ARR_DIM);

  state_t                state;
  logic                  ovl;
  logic                  prefetched;
  logic [RT_W-1:0]       r_n, r_idx, nr;
  logic [CT_W-1:0]       c_n, c_idx, nc;
  logic [KT_W-1:0]       k_n, k_idx, nk;
  logic [ADDR_WIDTH-1:0] bw, bd;
  logic                  last_tile;
  logic [RT_W-1:0]       row_clamp;
  logic [CT_W-1:0]       col_clamp;
  logic [KT_W-1:0]       k_clamp;
  logic                  zero_cnt;

  assign row_clamp = (row_tiles > RT_MAX) ? RT_MAX : row_tiles;
  assign col_clamp = (col_tiles > CT_MAX) ? CT_MAX : col_tiles;
  assign k_clamp   = (k_tiles > KT_MAX) ? KT_MAX : k_tiles;
  assign zero_cnt  = (row_tiles == '0) || (col_tiles == '0) || (k_tiles == '0);

  // Successor of the current tile in (r, c, k) order; k is innermost.
  always_comb begin
    nk        = k_idx + KT_W'(1);
    nc        = c_idx;
    nr        = r_idx;
    last_tile = 1'b0;
    if (k_idx == k_n - KT_W'(1)) begin
      nk = '0;
      nc = c_idx + CT_W'(1);
      if (c_idx == c_n - CT_W'(1)) begin
        nc = '0;
        nr = r_idx + RT_W'(1);
        last_tile = (r_idx == r_n - RT_W'(1));
      end
    end
  end

  function automatic logic [ADDR_WIDTH-1:0] w_addr(input logic [KT_W-1:0] k, input logic [CT_W-1:0] c);
    return bw + (ADDR_WIDTH'(k) * ADDR_WIDTH'(c_n) + ADDR_WIDTH'(c)) * ADDR_WIDTH'(SYS_ARR_DIM);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] d_addr(input logic [RT_W-1:0] r, input logic [KT_W-1:0] k);
    return bd + (ADDR_WIDTH'(r) * ADDR_WIDTH'(k_n) + ADDR_WIDTH'(k)) * ADDR_WIDTH'(SYS_ARR_DIM);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ovl         <= 1'b0;
      prefetched  <= 1'b0;
      r_n         <= '0;
      c_n         <= '0;
      k_n         <= '0;
      r_idx       <= '0;
      c_idx       <= '0;
      k_idx       <= '0;
      bw          <= '0;
      bd          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wmf_en      <= 1'b0;
      wfa_en      <= 1'b0;
      dmc_en      <= 1'b0;
      wmf_addr    <= '0;
      dmc_addr    <= '0;
      accum_row   <= '0;
      accum_col   <= '0;
      accum_clear <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ovl        <= overlap_mode;
            r_n        <= row_clamp;
            c_n        <= col_clamp;
            k_n        <= k_clamp;
            bw         <= base_weight;
            bd         <= base_data;
            r_idx      <= '0;
            c_idx      <= '0;
            k_idx      <= '0;
            prefetched <= 1'b0;
            if (zero_cnt) begin
              state <= FINISH;
            end else begin
              state    <= W_MEM_FIFO;
              busy     <= 1'b1;
              wmf_en   <= 1'b1;
              wmf_addr <= base_weight;
            end
          end
        end
        W_MEM_FIFO: begin
          if (wmf_done) begin
            wmf_en <= 1'b0;
            wfa_en <= 1'b1;
            state  <= W_FIFO_ARR;
          end
        end
        W_FIFO_ARR: begin
          if (wfa_done) begin
            wfa_en      <= 1'b0;
            dmc_en      <= 1'b1;
            dmc_addr    <= d_addr(r_idx, k_idx);
            accum_row   <= r_idx[RT_W-2:0];
            accum_col   <= c_idx[CT_W-2:0];
            accum_clear <= (k_idx == '0);
            if (ovl && !last_tile) begin
              wmf_en   <= 1'b1;
              wmf_addr <= w_addr(nk, nc);
            end
            state <= D_MEM_CALC;
          end
        end
        D_MEM_CALC: begin
          if (wmf_en && wmf_done) begin
            wmf_en     <= 1'b0;
            prefetched <= 1'b1;
          end
          if (dmc_done) begin
            dmc_en      <= 1'b0;
            accum_clear <= 1'b0;
            r_idx       <= nr;
            c_idx       <= nc;
            k_idx       <= nk;
            if (last_tile) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (!ovl) begin
              state    <= W_MEM_FIFO;
              wmf_en   <= 1'b1;
              wmf_addr <= w_addr(nk, nc);
            end else if (prefetched || (wmf_en && wmf_done)) begin
              state      <= W_FIFO_ARR;
              wfa_en     <= 1'b1;
              wmf_en     <= 1'b0;
              prefetched <= 1'b0;
            end else begin
              // Prefetch still in flight: keep wmf_en up and wait for it there.
              state <= W_MEM_FIFO;
            end
          end
        end
        FINISH: begin
          // Empty jobs arrive here with done low and spend one extra cycle raising it.
          if (!done) begin
            done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_tile_sequencer.sv
// tb/tb_master_tile_sequencer.sv - self-checking bench for master_tile_sequencer
module tb_master_tile_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        overlap_mode = 1'b0;
  logic [3:0]  row_tiles = '0, col_tiles = '0, k_tiles = '0;
  logic [15:0] base_weight = '0, base_data = '0;
  logic        wmf_done = 1'b0, wfa_done = 1'b0, dmc_done = 1'b0;
  logic        busy, done, wmf_en, wfa_en, dmc_en, accum_clear;
  logic [15:0] wmf_addr, dmc_addr;
  logic [2:0]  accum_row, accum_col;

  int checks = 0;
  int failures = 0;
  logic [15:0] ew[$], ed[$];
  int er[$], ec[$], ek[$];
  int scen_q[$];

  master_tile_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .overlap_mode(overlap_mode),
    .row_tiles(row_tiles), .col_tiles(col_tiles), .k_tiles(k_tiles),
    .base_weight(base_weight), .base_data(base_data),
    .busy(busy), .done(done),
    .wmf_en(wmf_en), .wmf_done(wmf_done), .wmf_addr(wmf_addr),
    .wfa_en(wfa_en), .wfa_done(wfa_done),
    .dmc_en(dmc_en), .dmc_done(dmc_done), .dmc_addr(dmc_addr),
    .accum_row(accum_row), .accum_col(accum_col), .accum_clear(accum_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected tile list straight from the loop nest and address formulas.
  task automatic build_model(input int rt, input int ct, input int kt,
                             input logic [15:0] bw, input logic [15:0] bd, output int n);
    int rr, cc, kk;
    rr = (rt > 8) ? 8 : rt;
    cc = (ct > 8) ? 8 : ct;
    kk = (kt > 8) ? 8 : kt;
    ew.delete(); ed.delete(); er.delete(); ec.delete(); ek.delete();
    for (int r = 0; r < rr; r++)
      for (int c = 0; c < cc; c++)
        for (int k = 0; k < kk; k++) begin
          ew.push_back(16'(int'(bw) + (k * cc + c) * 16));
          ed.push_back(16'(int'(bd) + (r * kk + k) * 16));
          er.push_back(r);
          ec.push_back(c);
          ek.push_back(k);
        end
    n = rr * cc * kk;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: wmf_done = 1'b1;
      1: wfa_done = 1'b1;
      2: dmc_done = 1'b1;
      default: begin wmf_done = 1'b1; dmc_done = 1'b1; end
    endcase
    @(negedge clk);
    wmf_done = 1'b0;
    wfa_done = 1'b0;
    dmc_done = 1'b0;
  endtask

  task automatic idle_cycles();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_job(input int rt, input int ct, input int kt, input bit ovl,
                         input logic [15:0] bw, input logic [15:0] bd, input int abort_at);
    int n;
    bit last;
    int s;
    build_model(rt, ct, kt, bw, bd, n);
    row_tiles = 4'(rt); col_tiles = 4'(ct); k_tiles = 4'(kt);
    overlap_mode = ovl; base_weight = bw; base_data = bd;
    start = 1'b1;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_wmf_en", wmf_en, 1);
    chk("start_wmf_addr", wmf_addr, ew[0]);
    // Second start with different config while busy must be ignored.
    row_tiles = 4'($urandom); col_tiles = 4'($urandom); k_tiles = 4'($urandom);
    overlap_mode = ~ovl; base_weight = 16'($urandom); base_data = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    idle_cycles();
    pulse(0);
    chk("wmf_drop", wmf_en, 0);
    chk("wfa_rise", wfa_en, 1);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      chk("wfa_en", wfa_en, 1);
      idle_cycles();
      pulse(1);
      chk("wfa_drop", wfa_en, 0);
      chk("dmc_en", dmc_en, 1);
      chk("dmc_addr", dmc_addr, ed[i]);
      chk("accum_row", accum_row, er[i]);
      chk("accum_col", accum_col, ec[i]);
      chk("accum_clear", accum_clear, (ek[i] == 0));
      chk("prefetch_en", wmf_en, (ovl && !last));
      if (ovl && !last) chk("prefetch_addr", wmf_addr, ew[i+1]);
      if (i == abort_at) return;
      if (!ovl || last) begin
        pulse(0);
        chk("spurious_wmf_wfa", wfa_en, 0);
        chk("spurious_wmf_dmc", dmc_en, 1);
        idle_cycles();
        pulse(2);
        chk("dmc_drop", dmc_en, 0);
        if (last) begin
          chk("done_pulse", done, 1);
          chk("done_busy", busy, 0);
          @(negedge clk);
          chk("done_width", done, 0);
          chk("idle_busy", busy, 0);
        end else begin
          chk("next_wmf_en", wmf_en, 1);
          chk("next_wmf_addr", wmf_addr, ew[i+1]);
          idle_cycles();
          pulse(0);
          chk("wmf_drop", wmf_en, 0);
          chk("wfa_rise", wfa_en, 1);
        end
      end else begin
        s = (scen_q.size() != 0) ? scen_q.pop_front() : int'($urandom_range(0, 2));
        idle_cycles();
        if (s == 0) begin
          pulse(0);
          chk("pf_wmf_drop", wmf_en, 0);
          chk("pf_dmc_held", dmc_en, 1);
          idle_cycles();
          pulse(2);
          chk("pf_wfa", wfa_en, 1);
          chk("pf_no_rewmf", wmf_en, 0);
          chk("pf_dmc_drop", dmc_en, 0);
        end else if (s == 1) begin
          pulse(3);
          chk("sim_wfa", wfa_en, 1);
          chk("sim_wmf_drop", wmf_en, 0);
          chk("sim_dmc_drop", dmc_en, 0);
        end else begin
          pulse(2);
          chk("late_dmc_drop", dmc_en, 0);
          chk("late_wmf_held", wmf_en, 1);
          chk("late_wfa_low", wfa_en, 0);
          chk("late_wmf_addr", wmf_addr, ew[i+1]);
          idle_cycles();
          pulse(0);
          chk("late_wmf_drop", wmf_en, 0);
          chk("late_wfa", wfa_en, 1);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wmf_en"}, wmf_en, 0);
    chk({tag, "_wfa_en"}, wfa_en, 0);
    chk({tag, "_dmc_en"}, dmc_en, 0);
    chk({tag, "_wmf_addr"}, wmf_addr, 0);
    chk({tag, "_dmc_addr"}, dmc_addr, 0);
    chk({tag, "_accum_row"}, accum_row, 0);
    chk({tag, "_accum_col"}, accum_col, 0);
    chk({tag, "_accum_clear"}, accum_clear, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);

    run_job(1, 1, 1, 0, 16'h0100, 16'h0200, -1);
    run_job(2, 2, 2, 0, 16'h0000, 16'h0000, -1);
    scen_q = '{0};
    run_job(1, 1, 2, 1, 16'h0000, 16'h0000, -1);
    scen_q = '{2, 1, 0};
    run_job(1, 2, 2, 1, 16'h0010, 16'h0020, -1);

    row_tiles = 4'd1; col_tiles = 4'd1; k_tiles = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_wmf_en", wmf_en, 0);
    chk("zero_done_early", done, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_wmf_en2", wmf_en, 0);
    @(negedge clk);
    chk("zero_done_width", done, 0);
    pulse(1);
    chk("spurious_wfa_en", wfa_en, 0);
    chk("spurious_wfa_busy", busy, 0);

    run_job(2, 2, 2, 0, 16'h0000, 16'h0000, 2);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
    end
    run_job(2, 2, 2, 0, 16'h0040, 16'h0080, -1);

    run_job(15, 1, 1, 0, 16'hFFF0, 16'hFF00, -1);
    run_job(1, 12, 2, 1, 16'hFF80, 16'h1234, -1);

    for (int j = 0; j < 6; j++) begin
      scen_q.delete();
      run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
